// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA job arbiter slice:
//   arb_state_t     - arbiter FSM state encoding (IDLE/LAUNCH/WAIT/RESP)
//   DEFAULT_WIDTH   - default operand/result width
//   DEFAULT_NUM_REQ - default requester count
//   id_width()      - width of a requester index (never less than 1 bit)
//   req_id_t        - requester index type for the default requester count
// ---------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_NUM_REQ = 4;

    // A single requester still needs a 1-bit id so that the ports stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [id_width(DEFAULT_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first set bit of req at or after
// ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  ID_W     highest-priority index (must be < NUM_REQ)
//   grant    out NUM_REQ  one-hot grant, all-zero when req is all-zero
//   grant_id out ID_W     index of the granted bit (0 when nothing granted)
// ---------------------------------------------------------------------------
module rr_arbiter
    import rsa_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit on the sum so ptr+k cannot overflow before the wrap.
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_job_arbiter
// Shares one modular-exponentiation engine between NUM_REQ requesters.
// One job is in flight at a time; requesters are served round-robin, the
// pointer moving to winner+1 once the response has been taken.
//
// Handshakes: every valid/ready pair transfers exactly on the rising edge
// where both are high; valid never waits for ready, and once valid is raised
// the payload is held stable until that transfer. req_ready is a one-hot
// grant offered only in IDLE; rsp_valid/rsp_id/rsp_data/rsp_err are held in
// RESP until rsp_ready.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid / req_ready         per-requester job handshake (one-hot ready)
//   req_msg, req_exp, req_mod     packed operands, requester i at [i*WIDTH +: WIDTH]
//   eng_start                     one-cycle engine launch pulse
//   eng_msg, eng_exp, eng_mod     registered engine operands
//   eng_done, eng_result          engine completion pulse and result
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_data, rsp_err     response payload
//   busy                          high whenever the FSM is not in IDLE
//   state_dbg                     current FSM state, for observation
//
// Optional feature: define RSA_ARB_TIMEOUT_EN to enable an engine watchdog;
// TIMEOUT_CYCLES after eng_start without eng_done, the job completes with
// rsp_data=0, rsp_err=1. Without the macro WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module rsa_job_arbiter
    import rsa_pkg::*;
#(
    parameter  int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter  int WIDTH          = DEFAULT_WIDTH,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_msg,
    input  logic [NUM_REQ*WIDTH-1:0] req_exp,
    input  logic [NUM_REQ*WIDTH-1:0] req_mod,
    output logic                     eng_start,
    output logic [WIDTH-1:0]         eng_msg,
    output logic [WIDTH-1:0]         eng_exp,
    output logic [WIDTH-1:0]         eng_mod,
    input  logic                     eng_done,
    input  logic [WIDTH-1:0]         eng_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output arb_state_t               state_dbg
);

    arb_state_t      state, state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               tmo_hit;

    logic [WIDTH-1:0] msg_arr [NUM_REQ];
    logic [WIDTH-1:0] exp_arr [NUM_REQ];
    logic [WIDTH-1:0] mod_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign msg_arr[i] = req_msg[i*WIDTH +: WIDTH];
        assign exp_arr[i] = req_exp[i*WIDTH +: WIDTH];
        assign mod_arr[i] = req_mod[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // The grant only ever covers valid requesters, so any grant bit in IDLE
    // is a completed handshake.
    assign accept = (state == ST_IDLE) && (|grant);

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    // Counts from the launch cycle, so the watchdog response appears exactly
    // TIMEOUT_CYCLES cycles after eng_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_LAUNCH || state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ST_WAIT) && !eng_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // A zero modulus is rejected without touching the engine.
                    state_next = (mod_arr[grant_id] != '0) ? ST_LAUNCH : ST_RESP;
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (eng_done || tmo_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job datapath: operands, winner, result, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_msg  <= '0;
            eng_exp  <= '0;
            eng_mod  <= '0;
            win_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            ptr      <= '0;
        end else begin
            if (accept) begin
                eng_msg  <= msg_arr[grant_id];
                eng_exp  <= exp_arr[grant_id];
                eng_mod  <= mod_arr[grant_id];
                win_id   <= grant_id;
                rsp_data <= '0;
                rsp_err  <= (mod_arr[grant_id] == '0);
            end
            if (state == ST_WAIT && eng_done) begin
                rsp_data <= eng_result;
                rsp_err  <= 1'b0;
            end else if (tmo_hit) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) begin
                ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        // rst_n gating keeps the grant low while reset is held, even with
        // requests pending.
        req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
        eng_start = (state == ST_LAUNCH);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
        rsp_id    = win_id;
        state_dbg = state;
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsa_job_arbiter
// Directed and randomized checks of rsa_job_arbiter against a reference model
// of round-robin selection and modular exponentiation. Define
// RSA_ARB_TIMEOUT_EN to also exercise the engine watchdog (TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_rsa_job_arbiter;
    import rsa_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_msg, req_exp, req_mod;
    logic             eng_start;
    logic [W-1:0]     eng_msg, eng_exp, eng_mod;
    logic             eng_done;
    logic [W-1:0]     eng_result;
    logic             rsp_valid, rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err, busy;
    arb_state_t       state_dbg;

    rsa_job_arbiter #(
        .NUM_REQ        (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_msg    (req_msg),
        .req_exp    (req_exp),
        .req_mod    (req_mod),
        .eng_start  (eng_start),
        .eng_msg    (eng_msg),
        .eng_exp    (eng_exp),
        .eng_mod    (eng_mod),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_launch = 0;
    int n_launch_exp = 0;
    int ptr_m = 0;

    logic [W-1:0] m_a [N];
    logic [W-1:0] x_a [N];
    logic [W-1:0] n_a [N];

    always @(posedge clk) begin
        if (eng_start) n_launch <= n_launch + 1;
    end

    // Reference model
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m,
                                                input logic [W-1:0] e,
                                                input logic [W-1:0] n);
        longint unsigned r, b, k;
        if (n == 0) return '0;
        r = 1 % longint'(n);
        b = longint'(m) % longint'(n);
        k = longint'(e);
        while (k != 0) begin
            if (k[0]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
            k = k >> 1;
        end
        return W'(r);
    endfunction

    function automatic int ref_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] m,
                           input logic [W-1:0] x, input logic [W-1:0] n);
        m_a[i] = m;
        x_a[i] = x;
        n_a[i] = n;
        req_msg[i*W +: W] = m;
        req_exp[i*W +: W] = x;
        req_mod[i*W +: W] = n;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        eng_done = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
    endtask

    // Serve the job the model expects to win next; done_delay = extra WAIT
    // cycles before eng_done, bp = cycles of response back-pressure.
    task automatic serve(input int done_delay, input int bp, input bit drop);
        int w;
        logic [W-1:0] m, x, n, e_data;
        logic e_err;
        #1;
        w = ref_pick(req_valid, ptr_m);
        if (w < 0) begin
            chk("no_pending_request", 64'(req_valid), 64'(1));
            return;
        end
        m = m_a[w];
        x = x_a[w];
        n = n_a[w];
        chk("grant", 64'(req_ready), 64'(4'b0001 << w));
        tick();
        if (drop) req_valid[w] = 1'b0;
        chk("ready_low_after_accept", 64'(req_ready), 64'(0));
        chk("busy_after_accept", 64'(busy), 64'(1));
        if (n == 0) begin
            chk("zero_mod_no_start", 64'(eng_start), 64'(0));
            e_data = '0;
            e_err = 1'b1;
        end else begin
            chk("eng_start", 64'(eng_start), 64'(1));
            chk("eng_ops", 64'({eng_msg, eng_exp, eng_mod}), 64'({m, x, n}));
            n_launch_exp++;
            tick();
            chk("start_one_cycle", 64'(eng_start), 64'(0));
            repeat (done_delay) tick();
            chk("wait_ops_stable", 64'({eng_msg, eng_exp, eng_mod}), 64'({m, x, n}));
            chk("wait_no_rsp", 64'({rsp_valid, req_ready}), 64'(0));
            eng_result = ref_modexp(m, x, n);
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            eng_result = W'($urandom);
            e_data = ref_modexp(m, x, n);
            e_err = 1'b0;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(w));
        chk("rsp_data", 64'(rsp_data), 64'(e_data));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        for (int i = 0; i < bp; i++) begin
            // Stray engine completions during RESP must not disturb the response.
            eng_done = 1'($urandom_range(0, 1));
            eng_result = W'($urandom);
            tick();
            chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready}),
                64'({1'b1, 2'(w), e_data, e_err, 4'b0000}));
        end
        eng_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_taken", 64'({rsp_valid, busy}), 64'(0));
        ptr_m = (w + 1) % N;
    endtask

    // Stimulus and checks
    initial begin
        int fair_order [5] = '{0, 1, 2, 3, 0};
        int w;
        int c0;

        req_msg = '0;
        req_exp = '0;
        req_mod = '0;
        eng_result = '0;
        for (int i = 0; i < N; i++) set_ops(i, '0, '0, '0);

        // Reset state
        rst_n = 1'b0;
        req_valid = '0;
        eng_done = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", 64'({req_ready, eng_start, rsp_valid, rsp_err, busy}), 64'(0));
        chk("reset_eng_ops", 64'({eng_msg, eng_exp, eng_mod}), 64'(0));
        chk("reset_rsp", 64'({rsp_id, rsp_data}), 64'(0));
        chk("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // rsp_ready and eng_done in IDLE do nothing
        rsp_ready = 1'b1;
        eng_done = 1'b1;
        eng_result = 16'h1234;
        tick();
        rsp_ready = 1'b0;
        eng_done = 1'b0;
        chk("idle_ignores_inputs", 64'({rsp_valid, busy, eng_start}), 64'(0));

        // Single job: 9^3 mod 33
        set_ops(0, 16'd9, 16'd3, 16'd33);
        req_valid = 4'b0001;
        serve(2, 0, 1'b1);

        // Fairness with all requesters holding valid
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom), W'($urandom_range(1, 65535)));
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("fair_order", 64'(req_ready), 64'(4'b0001 << fair_order[j]));
            serve($urandom_range(0, 3), 0, 1'b0);
        end
        req_valid = '0;

        // Zero modulus, with some back-pressure
        set_ops(2, 16'd5, 16'd7, 16'd0);
        req_valid = 4'b0100;
        serve(0, 3, 1'b1);

        // Long back-pressure with other requesters waiting
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom), W'($urandom_range(1, 65535)));
        req_valid = 4'b1011;
        serve(1, 10, 1'b1);
        req_valid = '0;

        // Withdrawn request leaves no trace
        req_valid = 4'b0010;
        #1;
        chk("withdraw_offered", 64'(req_ready), 64'(4'b0010));
        req_valid = '0;
        #1;
        chk("withdraw_ready_low", 64'(req_ready), 64'(0));
        tick();
        chk("withdraw_no_job", 64'({busy, eng_start, rsp_valid}), 64'(0));

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < N; i++) begin
                set_ops(i, W'($urandom), W'($urandom),
                        ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom_range(1, 65535)));
            end
            req_valid = N'($urandom_range(1, 15));
            serve($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        req_valid = '0;

        // Reset in the middle of WAIT
        set_ops(1, 16'd123, 16'd45, 16'd677);
        req_valid = 4'b0010;
        #1;
        w = ref_pick(req_valid, ptr_m);
        chk("midwait_grant", 64'(req_ready), 64'(4'b0001 << w));
        tick();
        req_valid = '0;
        chk("midwait_start", 64'(eng_start), 64'(1));
        n_launch_exp++;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_ctrl", 64'({req_ready, eng_start, rsp_valid, rsp_err, busy}), 64'(0));
        chk("midwait_reset_data", 64'({eng_msg, eng_exp, eng_mod}), 64'(0));
        chk("midwait_reset_rsp", 64'({rsp_id, rsp_data}), 64'(0));
        eng_done = 1'b1;
        eng_result = 16'hbeef;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
        eng_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midwait_no_rsp", 64'({rsp_valid, busy, rsp_data}), 64'(0));
        end

        // Pointer restarts at 0 after reset
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom), W'($urandom_range(1, 65535)));
        req_valid = 4'b1111;
        #1;
        chk("post_reset_ptr", 64'(req_ready), 64'(4'b0001));
        serve(0, 1, 1'b1);
        req_valid = '0;

`ifdef RSA_ARB_TIMEOUT_EN
        // Engine never completes: watchdog answers 8 cycles after eng_start
        set_ops(0, 16'd2, 16'd10, 16'd1000);
        req_valid = 4'b0001;
        #1;
        w = ref_pick(req_valid, ptr_m);
        chk("tmo_grant", 64'(req_ready), 64'(4'b0001 << w));
        tick();
        req_valid = '0;
        chk("tmo_start", 64'(eng_start), 64'(1));
        n_launch_exp++;
        c0 = cyc;
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        chk("tmo_latency", 64'(cyc - c0), 64'(8));
        chk("tmo_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({1'b1, 1'b1, 16'd0}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ptr_m = (w + 1) % N;
`else
        c0 = cyc;
`endif

        chk("launch_count", 64'(n_launch), 64'(n_launch_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/rsa_job_arbiter.md
RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one modular-exponentiation engine.
REQ-002 Parameter WIDTH, default 16, is the operand/result width.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, is the engine watchdog limit (used only with RSA_ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester job request.
REQ-007 req_ready  out  NUM_REQ  one-hot grant; job accepted when valid&ready.
REQ-008 req_msg, req_exp, req_mod  in  NUM_REQ*WIDTH each  packed message, exponent, modulus (requester i at [i*WIDTH +: WIDTH]).
REQ-009 eng_start  out  1  one-cycle engine launch pulse.
REQ-010 eng_msg, eng_exp, eng_mod  out  WIDTH each  registered operands to the engine, stable from eng_start until eng_done.
REQ-011 eng_done  in  1  engine completion pulse; eng_result  in  WIDTH  engine result, valid with eng_done.
REQ-012 rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  $clog2(NUM_REQ); rsp_data  out  WIDTH; rsp_err  out  1.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-015 IDLE: req_ready drives a one-hot grant to the first valid requester at or after the round-robin pointer (wrapping NUM_REQ-1 -> 0); req_ready is all-zero in other states.
REQ-016 On handshake, latch operands and the winner id; go to LAUNCH if modulus != 0, else go directly to RESP with rsp_data=0, rsp_err=1, and no engine launch.
REQ-017 LAUNCH: eng_start=1 for exactly one cycle; next state WAIT (accept-to-eng_start latency is 1 cycle).
REQ-018 WAIT: on eng_done, latch eng_result into rsp_data with rsp_err=0; next state RESP (rsp_valid rises 1 cycle after eng_done).
REQ-019 eng_done outside WAIT is ignored.
REQ-020 RESP: rsp_valid, rsp_id, rsp_data, and rsp_err held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE and set the pointer to winner+1 (mod NUM_REQ).
REQ-021 rsp_ready asserted before rsp_valid has no effect; back-pressure holds RESP indefinitely.
REQ-022 Requests arriving while busy are not accepted and are not lost as long as requesters hold valid.
REQ-023 Deasserting req_valid before a grant withdraws the request without side effects.

Reset
REQ-024 Rst_n low forces IDLE, pointer=0, and clears all of: req_ready, eng_start, eng_msg, eng_exp, eng_mod, rsp_valid, rsp_id, rsp_data, rsp_err, busy.
REQ-025 Reset mid-job abandons the job; no response is issued, and a late eng_done after reset is ignored.

Configuration
REQ-026 With macro RSA_ARB_TIMEOUT_EN defined, a counter runs in WAIT; reaching TIMEOUT_CYCLES without eng_done moves the FSM to RESP with rsp_data=0 and rsp_err=1.
REQ-027 Without RSA_ARB_TIMEOUT_EN, there is no counter and WAIT waits indefinitely.

Structure
REQ-028 Shared package rsa_pkg holds the FSM state enum, the default WIDTH constant, and the requester id width function/type.
REQ-029 Sub-module rr_arbiter (combinational round-robin one-hot pick from request vector and pointer) is instantiated once.

Verification
REQ-030 Single job: req0 msg=9, exp=3, mod=33; engine model returns 3 -> eng_start 1 cycle after accept, then rsp_id=0, rsp_data=3, rsp_err=0.
REQ-031 Fairness: all 4 requesters hold valid continuously -> grant order 0,1,2,3,0, one job in flight at a time.
REQ-032 Zero modulus: req2 mod=0 -> no eng_start, rsp_id=2, rsp_data=0, rsp_err=1.
REQ-033 Back-pressure: rsp_ready low for 10 cycles -> rsp_valid/rsp_data held stable, req_ready stays 0 throughout.
REQ-034 Reset mid-WAIT: Rst_n low, then eng_done pulse -> all outputs 0, no rsp_valid.
REQ-035 With RSA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, engine never completes -> rsp_err=1 with rsp_valid 8 cycles after eng_start.
